// File: rtl/prism_sp_desc_fetch_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_REQ descriptor-fetch engines.
// One burst is in flight at a time; R beats are routed to the owner and checked for length, response and ID.
module prism_sp_desc_fetch_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 6
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_arvalid,
  output logic [NUM_REQ-1:0]            req_arready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr,
  input  logic [NUM_REQ*8-1:0]          req_arlen,
  output logic [NUM_REQ-1:0]            req_rvalid,
  input  logic [NUM_REQ-1:0]            req_rready,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          req_rlast,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic [7:0]                    m_arlen,
  output logic [ID_WIDTH-1:0]           m_arid,
  output logic [2:0]                    m_arsize,
  output logic [1:0]                    m_arburst,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_rlast,
  input  logic [1:0]                    m_rresp,
  input  logic [ID_WIDTH-1:0]           m_rid,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
  output logic                          err,
  input  logic                          err_clear
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [GW-1:0]   last_grant_r;
  logic [7:0]      beat_cnt_r;
  logic [GW-1:0]   pick_idx_s;
  logic [GW-1:0]   cand_s;
  logic            pick_valid_s;
  logic            grant_fire_s;
  logic            r_hs_s;
  logic            err_event_s;

  assign m_arsize  = 3'($clog2(DATA_WIDTH/8));
  assign m_arburst = 2'b01;
  assign m_arid    = ID_WIDTH'(grant_idx);
  assign req_rdata = m_rdata;
  assign req_rlast = m_rlast;

  // Round-robin pick: first valid requester after the last one served.
  always_comb begin
    pick_valid_s = 1'b0;
    pick_idx_s   = '0;
    cand_s       = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = GW'((int'(last_grant_r) + i) % NUM_REQ);
      if (!pick_valid_s && req_arvalid[cand_s]) begin
        pick_valid_s = 1'b1;
        pick_idx_s   = cand_s;
      end else begin
        pick_valid_s = pick_valid_s;
      end
    end
  end

  assign grant_fire_s = (state_r == ST_IDLE) && enable && pick_valid_s;
  assign r_hs_s       = (state_r == ST_R) && m_rvalid && req_rready[grant_idx];
  // rlast must coincide exactly with the counter reaching zero
  assign err_event_s  = r_hs_s && ((m_rlast != (beat_cnt_r == 8'd0)) ||
                                   (m_rresp != 2'b00) || (m_rid != m_arid));

  // Next-state decode plus request-accept and R routing.
  always_comb begin
    state_s     = state_r;
    req_arready = '0;
    req_rvalid  = '0;
    m_rready    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_fire_s) begin
          req_arready[pick_idx_s] = 1'b1;
          state_s                 = ST_AR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_AR: begin
        if (m_arready) begin
          state_s = ST_R;
        end else begin
          state_s = ST_AR;
        end
      end
      ST_R: begin
        req_rvalid[grant_idx] = m_rvalid;
        m_rready              = req_rready[grant_idx];
        if (r_hs_s && m_rlast) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_R;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Burst bookkeeping registers and AR channel outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      m_arvalid    <= 1'b0;
      m_araddr     <= '0;
      m_arlen      <= 8'd0;
      grant_idx    <= '0;
      last_grant_r <= GW'(NUM_REQ - 1);
      busy         <= 1'b0;
      beat_cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      if (grant_fire_s) begin
        m_araddr   <= req_araddr[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
        m_arlen    <= req_arlen[int'(pick_idx_s)*8 +: 8];
        beat_cnt_r <= req_arlen[int'(pick_idx_s)*8 +: 8];
        grant_idx  <= pick_idx_s;
        m_arvalid  <= 1'b1;
        busy       <= 1'b1;
      end else if ((state_r == ST_AR) && m_arready) begin
        m_arvalid <= 1'b0;
      end else if (r_hs_s) begin
        beat_cnt_r <= beat_cnt_r - 8'd1;
        if (m_rlast) begin
          last_grant_r <= grant_idx;
          busy         <= 1'b0;
        end
      end
    end
  end

  // Sticky error flag; a new error takes priority over clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err <= 1'b0;
    end else if (err_event_s) begin
      err <= 1'b1;
    end else if (err_clear) begin
      err <= 1'b0;
    end
  end

endmodule
